// File: rtl/iod_dly_tap_ctrl_if.sv
// iod_dly_tap_ctrl_if: request/status and IOD delay-line signals of one tap-controller lane
interface iod_dly_tap_ctrl_if #(parameter int TAP_W = 8);
  logic             TAP_REQ;
  logic [TAP_W-1:0] TAP_TARGET;
  logic             LOAD_REQ;
  logic             DELAY_LINE_OUT_OF_RANGE;
  logic             DELAY_LINE_MOVE;
  logic             DELAY_LINE_DIRECTION;
  logic             DELAY_LINE_LOAD;
  logic [TAP_W-1:0] TAP_CUR;
  logic             BUSY;
  logic             DONE;
  logic             ERR_RANGE;
  logic             ERR_OOR;
  modport master (
    output TAP_REQ, TAP_TARGET, LOAD_REQ, DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, TAP_CUR, BUSY, DONE, ERR_RANGE, ERR_OOR
  );
  modport slave (
    input  TAP_REQ, TAP_TARGET, LOAD_REQ, DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, TAP_CUR, BUSY, DONE, ERR_RANGE, ERR_OOR
  );
endinterface

// File: rtl/iod_dly_tap_ctrl.sv
// iod_dly_tap_ctrl: turns absolute tap requests into paced single-step IOD delay-line moves
module iod_dly_tap_ctrl #(
  parameter int TAP_W      = 8,
  parameter int INIT_TAP   = 1,
  parameter int MAX_TAP    = 127,
  parameter int SETTLE_CYC = 4
) (
  input logic FAB_CLK,
  input logic ARST,
  iod_dly_tap_ctrl_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [2:0] {S_IDLE, S_LDP, S_DIR, S_MOVE, S_SETTLE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d, tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, ld_q, ld_d, erng_q, erng_d, eoor_q, eoor_d;
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) begin
      state_q <= S_IDLE;
      tap_q   <= TAP_W'(INIT_TAP);
      tgt_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ld_q    <= 1'b0;
      erng_q  <= 1'b0;
      eoor_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ld_q    <= ld_d;
      erng_q  <= erng_d;
      eoor_q  <= eoor_d;
    end
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ld_d    = ld_q;
    erng_d  = erng_q;
    eoor_d  = eoor_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.LOAD_REQ || bus.TAP_REQ) begin
          erng_d = 1'b0;
          eoor_d = 1'b0;
          ld_d   = bus.LOAD_REQ;
          if (bus.LOAD_REQ) state_d = S_LDP;
          else if (bus.TAP_TARGET > TAP_W'(MAX_TAP)) begin
            erng_d  = 1'b1;
            state_d = S_DONE;
          end else if (bus.TAP_TARGET == tap_q) state_d = S_DONE;
          else begin
            tgt_d   = bus.TAP_TARGET;
            dir_d   = bus.TAP_TARGET > tap_q;
            state_d = S_DIR;
          end
        end
      end
      S_LDP: begin
        tap_d   = TAP_W'(INIT_TAP);
        cnt_d   = CW'(SETTLE_CYC - 1);
        state_d = S_SETTLE;
      end
      S_DIR: state_d = S_MOVE;
      S_MOVE: begin
        tap_d   = dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
        cnt_d   = CW'(SETTLE_CYC - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE:
        // out-of-range only matters on the last settle cycle, and never after a load
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (ld_q) state_d = S_DONE;
        else if (bus.DELAY_LINE_OUT_OF_RANGE) begin
          eoor_d  = 1'b1;
          state_d = S_DONE;
        end else state_d = tap_q == tgt_q ? S_DONE : S_MOVE;
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.DELAY_LINE_MOVE      = state_q == S_MOVE;
  assign bus.DELAY_LINE_LOAD      = state_q == S_LDP;
  assign bus.DELAY_LINE_DIRECTION = dir_q;
  assign bus.TAP_CUR              = tap_q;
  assign bus.BUSY                 = state_q inside {S_LDP, S_DIR, S_MOVE, S_SETTLE};
  assign bus.DONE                 = state_q == S_DONE;
  assign bus.ERR_RANGE            = erng_q;
  assign bus.ERR_OOR              = eoor_q;
endmodule

// File: tb/tb_iod_dly_tap_ctrl.sv
// tb_iod_dly_tap_ctrl: scoreboard bench; expected outcomes come from a transaction-level tap model
module tb_iod_dly_tap_ctrl;
  localparam int TW = 8, INIT = 1, MAX = 127, S = 4, P = 1 + S;
  logic clk = 1'b0, arst = 1'b1;
  always #5 clk = ~clk;
  iod_dly_tap_ctrl_if #(.TAP_W(TW)) bus();
  iod_dly_tap_ctrl #(.TAP_W(TW), .INIT_TAP(INIT), .MAX_TAP(MAX), .SETTLE_CYC(S)) dut (
    .FAB_CLK(clk), .ARST(arst), .bus(bus)
  );
  typedef struct {int issue; int lat; int tap; int erng; int eoor; int moves; int loads; int busy; int dir;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, model_tap = INIT;
  int n_mv = 0, n_ld = 0, n_busy = 0, prev_mv = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // one request resolved into its observable outcome: latency, final tap, flags, pulse counts
  function automatic exp_t model(input bit ld, input int tgt, input int ok, input int issue);
    exp_t e;
    int n, st;
    e = '{issue, 1, model_tap, 0, 0, 0, 0, 0, 0};
    if (ld) begin
      e.lat = 2 + S; e.tap = INIT; e.loads = 1; e.busy = 1 + S;
    end else if (tgt > MAX) e.erng = 1;
    else if (tgt != model_tap) begin
      n = tgt > model_tap ? tgt - model_tap : model_tap - tgt;
      st = ok > 0 ? ok : n;
      e.dir = int'(tgt > model_tap);
      e.tap = e.dir != 0 ? model_tap + st : model_tap - st;
      e.eoor = int'(ok > 0);
      e.moves = st;
      e.lat = 2 + st * P;
      e.busy = e.lat - 1;
    end
    model_tap = e.tap;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      n_mv = 0; n_ld = 0; n_busy = 0; prev_mv = 0;
    end else begin
      chk("move_load_excl", int'(bus.DELAY_LINE_MOVE && bus.DELAY_LINE_LOAD), 0);
      chk("move_not_back2back", int'(bus.DELAY_LINE_MOVE && prev_mv != 0), 0);
      chk("tap_in_range", int'(bus.TAP_CUR > MAX), 0);
      n_mv += int'(bus.DELAY_LINE_MOVE);
      n_ld += int'(bus.DELAY_LINE_LOAD);
      n_busy += int'(bus.BUSY);
      if (bus.DONE) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_latency", cyc - e.issue, e.lat);
          chk("tap_cur", int'(bus.TAP_CUR), e.tap);
          chk("err_range", int'(bus.ERR_RANGE), e.erng);
          chk("err_oor", int'(bus.ERR_OOR), e.eoor);
          chk("move_pulses", n_mv, e.moves);
          chk("load_pulses", n_ld, e.loads);
          chk("busy_cycles", n_busy, e.busy);
          if (e.moves > 0) chk("direction", int'(bus.DELAY_LINE_DIRECTION), e.dir);
        end
        n_mv = 0; n_ld = 0; n_busy = 0;
      end
      prev_mv = int'(bus.DELAY_LINE_MOVE);
    end
  end
  task automatic wait_done();
    for (int k = 0; k < 80 && sb.size() > 0; k++) begin
      @(negedge clk); #1;
      bus.LOAD_REQ = 1'b0; bus.TAP_REQ = 1'b0;
    end
    if (sb.size() > 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  // ok: step index whose settle sees out-of-range (for loads: any nonzero raises it during the load)
  task automatic issue(input bit ld, input bit tr, input int tgt, input int ok, input int spur);
    exp_t e;
    int oj;
    e = model(ld, tgt, ok, cyc);
    sb.push_back(e);
    bus.LOAD_REQ = ld; bus.TAP_REQ = tr; bus.TAP_TARGET = TW'(tgt);
    bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
    oj = ok == 0 ? 0 : ld ? 1 : 2 + (ok - 1) * P;
    for (int j = 1; j < e.lat; j++) begin
      @(negedge clk); #1;
      bus.LOAD_REQ = 1'b0; bus.TAP_REQ = 1'b0;
      if (j == oj) bus.DELAY_LINE_OUT_OF_RANGE = 1'b1;
      if (j == spur) begin
        bus.TAP_REQ = 1'b1;
        bus.LOAD_REQ = 1'($urandom_range(0, 1));
        bus.TAP_TARGET = TW'($urandom_range(0, MAX));
      end
    end
    wait_done();
  endtask
  initial begin
    int c, r, tgt, ok, d;
    bit ld, tr;
    bus.TAP_REQ = 1'b0; bus.LOAD_REQ = 1'b0; bus.TAP_TARGET = '0; bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tap", int'(bus.TAP_CUR), INIT);
    chk("rst_move", int'(bus.DELAY_LINE_MOVE), 0);
    chk("rst_dir", int'(bus.DELAY_LINE_DIRECTION), 0);
    chk("rst_load", int'(bus.DELAY_LINE_LOAD), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_errs", int'({bus.ERR_RANGE, bus.ERR_OOR}), 0);
    #1 arst = 1'b0;
    @(negedge clk); #1;
    issue(0, 1, 4, 0, 0);
    issue(0, 1, 2, 0, 0);
    issue(0, 1, 2, 0, 0);
    issue(0, 1, 200, 0, 0);
    issue(0, 1, 10, 0, 0);
    issue(0, 1, 20, 3, 0);
    issue(0, 1, 30, 0, 0);
    issue(1, 1, 77, 0, 3);
    c = cyc;
    bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
    bus.TAP_REQ = 1'b1; bus.TAP_TARGET = TW'(model_tap + 5);
    @(negedge clk); #1;
    bus.TAP_REQ = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("pre_rst_cycle", cyc - c, 8);
    chk("pre_rst_busy", int'(bus.BUSY), 1);
    arst = 1'b1;
    #1;
    chk("arst_move", int'(bus.DELAY_LINE_MOVE), 0);
    chk("arst_busy", int'(bus.BUSY), 0);
    chk("arst_done", int'(bus.DONE), 0);
    chk("arst_tap", int'(bus.TAP_CUR), INIT);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    model_tap = INIT;
    sb.delete();
    #1;
    issue(0, 1, 2, 0, 0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      ld = 1'b0; tr = 1'b1; ok = 0;
      tgt = $urandom_range(0, MAX);
      if (r < 10) begin ld = 1'b1; tr = 1'b0; end
      else if (r < 20) ld = 1'b1;
      else if (r < 25) tgt = $urandom_range(MAX + 1, 255);
      else if (r < 35) tgt = model_tap;
      else begin
        tgt = model_tap + $urandom_range(0, 16) - 8;
        tgt = tgt < 0 ? 0 : tgt > MAX ? MAX : tgt;
      end
      if (ld) ok = r % 2;
      else if (tgt <= MAX && tgt != model_tap && $urandom_range(0, 3) == 0) begin
        d = tgt > model_tap ? tgt - model_tap : model_tap - tgt;
        ok = $urandom_range(1, d);
      end
      repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
      issue(ld, tr, tgt, ok, $urandom_range(1, 30));
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
